// File: rtl/mult32_seq_ctrl.sv
// Sequential 32x32 signed/unsigned multiplier: one radix-2 shift-add step per cycle,
// sign handled by magnitude capture and a final conditional negate.
module mult32_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   mag_a, mag_b, addend;
    logic [WIDTH:0]     sum;
    logic [ACC_W-1:0]   prod;

    // Accumulator holds {partial product, remaining multiplier bits}; each step adds and shifts right.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        mag_a  = (SIGNED && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
        mag_b  = (SIGNED && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
        addend = acc_q[0] ? mcand_q : '0;
        sum    = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, addend};
        prod   = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    mcand_d = mag_a;
                    acc_d   = {WIDTH'(0), mag_b};
                    neg_d   = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                {hi_d, lo_d} = prod;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Directed self-checking bench for mult32_seq_ctrl: products, latency, operand
// stability, START-in-DONE handling and reset behaviour.
module tb_mult32_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [10];

    mult32_seq_ctrl #(.WIDTH(32)) dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .SIGNED (sgn),
        .A      (a),
        .B      (b),
        .BUSY   (busy),
        .DONE   (done),
        .HI     (hi),
        .LO     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at the negedge right after the accept edge; counts edges until DONE is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_mult(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                           output logic [63:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; a = va; b = vb; sgn = vs;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        res = {hi, lo};
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("idle_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] prev;
        int          lat;
        int          pulses;

        vecs[0] = '{32'd3781,     32'd7132,     1'b0, 64'd26966092};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
        vecs[2] = '{32'hFFFFFFFE, 32'd5,        1'b1, 64'hFFFFFFFF_FFFFFFF6};
        vecs[3] = '{32'd3781,     -32'sd7132,   1'b1, {32'hFFFFFFFF, 32'd4268001204}};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1};
        vecs[5] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
        vecs[6] = '{32'd0,        -32'sd5,      1'b1, 64'd0};
        vecs[7] = '{32'h80000000, 32'd2,        1'b0, 64'h00000001_00000000};
        vecs[8] = '{32'hFFFFFFFE, 32'd5,        1'b0, 64'h00000004_FFFFFFF6};
        vecs[9] = '{32'd7,        -32'sd3,      1'b1, 64'hFFFFFFFF_FFFFFFEB};

        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);

        // Directed product vectors
        for (int i = 0; i < 10; i++) begin
            do_mult(vecs[i].a, vecs[i].b, vecs[i].s, res, lat);
            chk($sformatf("prod%0d", i), res, vecs[i].exp);
            chk($sformatf("lat%0d", i), 64'(lat), 64'd33);
        end

        // Operand changes and a START pulse mid-CALC must not disturb the result
        prev = {hi, lo};
        @(negedge clk);
        start = 1'b1; a = 32'd1234; b = 32'd5678; sgn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("hold_prev_hilo", {hi, lo}, prev);
        a = 32'hDEADBEEF; b = 32'h12345678; sgn = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_mid_op", {63'd0, busy}, 64'd1);
        lat = 11;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) chk("busy_until_done", {63'd0, busy}, 64'd1);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("stable_lat", 64'(lat), 64'd33);
        chk("stable_prod", {hi, lo}, 64'd7006652);
        @(negedge clk);
        chk("stable_no_restart", {63'd0, busy}, 64'd0);

        // START held through DONE: ignored in DONE, accepted in the next IDLE cycle
        @(negedge clk);
        start = 1'b1; a = 32'd6; b = 32'd7; sgn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wait_done(lat);
        chk("held_lat", 64'(lat), 64'd33);
        chk("held_prod", {hi, lo}, 64'd42);
        @(negedge clk);
        chk("held_idle_gap", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("held_reaccept", {63'd0, busy}, 64'd1);
        start = 1'b0; a = 32'd100; b = 32'd100;
        wait_done(lat);
        chk("held_lat2", 64'(lat), 64'd33);
        chk("held_prod2", {hi, lo}, 64'd42);

        // Reset at CALC step 20 aborts with no DONE and clears HI/LO
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 32'd3781; b = 32'd7132; sgn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("midrst_quiet", 64'(pulses), 64'd0);
        do_mult(32'd2, 32'd5, 1'b0, res, lat);
        chk("post_rst_prod", res, 64'd10);
        chk("post_rst_lat", 64'(lat), 64'd33);

        // START coincident with reset is ignored
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", {63'd0, busy}, 64'd0);
        chk("rst_start_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        chk("rst_start_stay", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
